// File: rtl/des_pkg.sv
// Shared 3DES datapath types: 64-bit blocks, 32-bit host words and the
// word-select encoding used when a block is serialised.
package des_pkg;

  localparam int DES_WORDS_PER_BLOCK = 2;
  localparam int DES_WORD_W          = 64 / DES_WORDS_PER_BLOCK;

  typedef logic [0:63]           des_block_t;
  typedef logic [0:DES_WORD_W-1] des_word_t;

  typedef enum logic {
    WORD_HI = 1'b0,
    WORD_LO = 1'b1
  } word_sel_e;

  // Bit 0 is the MSB, so the high word is the first half of the block.
  function automatic des_word_t des_word_of(input des_block_t blk, input word_sel_e sel);
    return (sel == WORD_HI) ? blk[0:DES_WORD_W-1] : blk[DES_WORD_W:63];
  endfunction

endpackage

// File: rtl/des_block_fifo.sv
// Generic synchronous FIFO with power-of-2 depth; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module des_block_fifo
  import des_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = des_block_t
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;
  T              mem_q [DEPTH];

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (n_rst && push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/des_output_buffer.sv
// Buffers 3DES pipeline output blocks and serialises them as two 32-bit words
// to the host, with a credit counter that keeps the non-stalling pipeline safe.
module des_output_buffer
  import des_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       blk_valid_in,
  input  des_block_t blk_in,
  input  logic       issue_in,
  output logic       credit_ok,
  output logic       rd_valid,
  input  logic       rd_ready,
  output des_word_t  rd_data,
  output logic       rd_last,
  output logic [6:0] occupancy,
  output logic       overflow_err,
  output word_sel_e  dbg_word_sel
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Read port: a word moves when rd_valid & rd_ready; rd_data/rd_last are a
  // function of registered state only, so they hold while the host stalls.
  word_sel_e         state_q, state_d;
  logic [CW-1:0]     in_flight_q, in_flight_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     count;
  logic              full, empty, xfer, pop, drop;
  des_block_t        head;
  logic [7:0]        credit_sum;

  des_block_fifo #(
    .DEPTH (DEPTH),
    .T     (des_block_t)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (blk_valid_in),
    .data_i  (blk_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign rd_valid = !empty;
  assign xfer     = rd_valid && rd_ready;
  assign pop      = xfer && (state_q == WORD_LO);
  assign drop     = blk_valid_in && full && !pop;

  assign rd_data  = rd_valid ? des_word_of(head, state_q) : '0;
  assign rd_last  = rd_valid && (state_q == WORD_LO);

  assign occupancy    = 7'(count);
  assign overflow_err = ovf_q;
  assign dbg_word_sel = state_q;

  // Pops are credited only once they show up in the registered count.
  assign credit_sum = 8'(count) + 8'(in_flight_q) + 8'(issue_in);
  assign credit_ok  = (credit_sum < 8'(DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      WORD_HI: if (xfer) state_d = WORD_LO;
      WORD_LO: if (xfer) state_d = WORD_HI;
      default: state_d = WORD_HI;
    endcase
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (issue_in && !blk_valid_in) begin
      in_flight_d = in_flight_q + 1'b1;
    end else if (blk_valid_in && !issue_in && (in_flight_q != '0)) begin
      in_flight_d = in_flight_q - 1'b1;
    end
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= WORD_HI;
      in_flight_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= in_flight_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_des_output_buffer.sv
// Bench for des_output_buffer: directed cycle table plus scoreboarded
// sequences for full/overflow, push-on-final-pop and stalled host reads.
module tb_des_output_buffer;
  import des_pkg::*;

  localparam int DEPTH = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        blk_valid_in = 1'b0;
  logic [63:0] blk_in = 64'h0;
  logic        issue_in = 1'b0;
  logic        rd_ready = 1'b0;
  logic        credit_ok, rd_valid, rd_last, overflow_err;
  logic [31:0] rd_data;
  logic [6:0]  occupancy;
  word_sel_e   dbg_word_sel;

  des_output_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .blk_valid_in (blk_valid_in),
    .blk_in       (blk_in),
    .issue_in     (issue_in),
    .credit_ok    (credit_ok),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .occupancy    (occupancy),
    .overflow_err (overflow_err),
    .dbg_word_sel (dbg_word_sel)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int widx = 0;

  typedef struct {
    logic        rst;
    logic        v;
    logic [63:0] b;
    logic        iss;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
    logic [6:0]  e_occ;
    logic        e_credit;
  } vec_t;

  vec_t vt[22];

  localparam logic [63:0] B0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] B1 = 64'hA1A1A1A1_51515151;
  localparam logic [63:0] B2 = 64'hB2B2B2B2_62626262;
  localparam logic [63:0] B3 = 64'hC3C3C3C3_73737373;
  localparam logic [63:0] B4 = 64'hD4D4D4D4_84848484;
  localparam logic [63:0] B5 = 64'hE5E5E5E5_95959595;
  localparam logic [63:0] B6 = 64'hF6F6F6F6_06060606;
  localparam logic [63:0] Z  = 64'h0;

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [63:0] b,
                       input logic iss, input logic rdy);
    n_rst        = r;
    blk_valid_in = v;
    blk_in       = b;
    issue_in     = iss;
    rd_ready     = rdy;
  endtask

  task automatic do_reset();
    drive(L, L, Z, L, L);
    @(negedge clk);
    drive(H, L, Z, L, L);
    exp_q.delete();
    widx = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_step();
    logic [31:0] exp_w;
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got word %h expected none", rd_data);
      end else begin
        exp_w = (widx == 0) ? exp_q[0][63:32] : exp_q[0][31:0];
        chk("sb_data", 64'(rd_data), 64'(exp_w));
        chk("sb_last", 64'(rd_last), (widx == 1) ? 64'h1 : 64'h0);
        if (widx == 1) void'(exp_q.pop_front());
        widx = 1 - widx;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [63:0] b, input logic iss, input logic rdy);
    drive(H, v, b, iss, rdy);
    #1;
    sb_step();
    @(negedge clk);
  endtask

  task automatic fill(input int n);
    logic [63:0] b;
    for (int i = 0; i < n; i++) begin
      b = {$urandom, $urandom};
      exp_q.push_back(b);
      cyc(H, b, L, L);
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 64 && exp_q.size() > 0; n++) cyc(L, Z, L, H);
    chk({name, "_drained"}, 64'(exp_q.size()), 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] b;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    int          sent;

    // Columns: rst v blk iss rdy | rd_valid rd_data rd_last occupancy credit_ok
    vt[0]  = '{H, L, Z,  L, H,  L, 32'h0,        L, 7'd0, H};
    vt[1]  = '{H, H, B0, L, H,  L, 32'h0,        L, 7'd0, H};
    vt[2]  = '{H, L, Z,  L, H,  H, 32'h01234567, L, 7'd1, H};
    vt[3]  = '{H, L, Z,  L, H,  H, 32'h89ABCDEF, H, 7'd1, H};
    vt[4]  = '{H, L, Z,  L, H,  L, 32'h0,        L, 7'd0, H};
    vt[5]  = '{H, H, B1, L, L,  L, 32'h0,        L, 7'd0, H};
    vt[6]  = '{H, H, B2, L, L,  H, 32'hA1A1A1A1, L, 7'd1, H};
    vt[7]  = '{H, H, B3, L, L,  H, 32'hA1A1A1A1, L, 7'd2, H};
    vt[8]  = '{H, H, B4, L, L,  H, 32'hA1A1A1A1, L, 7'd3, H};
    vt[9]  = '{H, H, B5, L, L,  H, 32'hA1A1A1A1, L, 7'd4, H};
    vt[10] = '{H, L, Z,  H, L,  H, 32'hA1A1A1A1, L, 7'd5, H};
    vt[11] = '{H, L, Z,  H, L,  H, 32'hA1A1A1A1, L, 7'd5, H};
    vt[12] = '{H, L, Z,  H, L,  H, 32'hA1A1A1A1, L, 7'd5, L};
    vt[13] = '{H, L, Z,  L, L,  H, 32'hA1A1A1A1, L, 7'd5, L};
    vt[14] = '{H, L, Z,  L, H,  H, 32'hA1A1A1A1, L, 7'd5, L};
    vt[15] = '{H, L, Z,  L, H,  H, 32'h51515151, H, 7'd5, L};
    vt[16] = '{H, L, Z,  L, L,  H, 32'hB2B2B2B2, L, 7'd4, H};
    vt[17] = '{H, H, B6, L, H,  H, 32'hB2B2B2B2, L, 7'd4, H};
    vt[18] = '{H, L, Z,  L, H,  H, 32'h62626262, H, 7'd5, H};
    vt[19] = '{L, H, B1, H, L,  H, 32'hC3C3C3C3, L, 7'd4, H};
    vt[20] = '{H, L, Z,  L, L,  L, 32'h0,        L, 7'd0, H};
    vt[21] = '{H, L, Z,  H, L,  L, 32'h0,        L, 7'd0, H};

    @(negedge clk);
    do_reset();

    // Single block round trip, credit accounting, pop credit delay, mid-run reset.
    for (int i = 0; i < 22; i++) begin
      drive(vt[i].rst, vt[i].v, vt[i].b, vt[i].iss, vt[i].rdy);
      #1;
      chk($sformatf("v%0d_rd_valid", i), 64'(rd_valid), 64'(vt[i].e_valid));
      chk($sformatf("v%0d_rd_data", i), 64'(rd_data), 64'(vt[i].e_data));
      chk($sformatf("v%0d_rd_last", i), 64'(rd_last), 64'(vt[i].e_last));
      chk($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vt[i].e_occ));
      chk($sformatf("v%0d_credit_ok", i), 64'(credit_ok), 64'(vt[i].e_credit));
      chk($sformatf("v%0d_overflow", i), 64'(overflow_err), 64'h0);
      @(negedge clk);
    end

    // Fill to DEPTH, overflow on the next strobe, then drain in order.
    do_reset();
    fill(DEPTH);
    drive(H, L, Z, L, L);
    #1;
    chk("full_occupancy", 64'(occupancy), 64'(DEPTH));
    chk("full_credit_ok", 64'(credit_ok), 64'h0);
    chk("full_overflow_pre", 64'(overflow_err), 64'h0);
    @(negedge clk);
    cyc(H, 64'hDEADBEEF_CAFEF00D, L, L);
    drive(H, L, Z, L, L);
    #1;
    chk("ovf_set", 64'(overflow_err), 64'h1);
    chk("ovf_occupancy", 64'(occupancy), 64'(DEPTH));
    @(negedge clk);
    drain("ovf");
    drive(H, L, Z, L, L);
    #1;
    chk("ovf_sticky", 64'(overflow_err), 64'h1);
    chk("ovf_empty_occ", 64'(occupancy), 64'h0);
    @(negedge clk);

    // Full FIFO, strobe coinciding with the final-word pop.
    do_reset();
    fill(DEPTH);
    cyc(L, Z, L, H);
    b = 64'h13579BDF_2468ACE0;
    drive(H, H, b, L, H);
    #1;
    sb_step();
    exp_q.push_back(b);
    @(negedge clk);
    drive(H, L, Z, L, L);
    #1;
    chk("pushpop_occupancy", 64'(occupancy), 64'(DEPTH));
    chk("pushpop_overflow", 64'(overflow_err), 64'h0);
    @(negedge clk);
    drain("pushpop");

    // Host ready toggling 1010..., 20 blocks paced by credit_ok.
    do_reset();
    sent = 0;
    prev_stall = 1'b0;
    prev_data = 32'h0;
    prev_last = 1'b0;
    for (int n = 0; n < 400 && (sent < 20 || exp_q.size() > 0); n++) begin
      drive(H, L, Z, L, (n % 2 == 0) ? H : L);
      #1;
      if (sent < 20 && credit_ok) begin
        b = {$urandom, $urandom};
        blk_valid_in = 1'b1;
        blk_in = b;
        exp_q.push_back(b);
        sent++;
      end
      if (prev_stall) begin
        chk("stall_data", 64'(rd_data), 64'(prev_data));
        chk("stall_last", 64'(rd_last), 64'(prev_last));
      end
      sb_step();
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
      @(negedge clk);
    end
    chk("toggle_sent", 64'(sent), 64'd20);
    chk("toggle_drained", 64'(exp_q.size()), 64'h0);
    chk("toggle_overflow", 64'(overflow_err), 64'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
